// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the writeback port arbiter: core configuration, transaction id width
// and the exception record carried alongside each functional-unit result.
package wb_port_arbiter_pkg;

  typedef struct packed {
    logic [31:0] XLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32'd64};

  localparam int unsigned TRANS_ID_BITS = 3;

  typedef struct packed {
    logic [31:0] cause;
    logic [31:0] tval;
    logic        valid;
  } exception_t;

  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_arb_slot.sv
// One-entry holding slot for a functional-unit result waiting for the shared writeback port.
module wb_arb_slot
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TID_W = TRANS_ID_BITS
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic             flush_i,
  input  logic [TID_W-1:0] trans_id_i,
  input  logic [XLEN-1:0]  data_i,
  input  exception_t       ex_i,
  output logic             occupied_o,
  output logic [TID_W-1:0] trans_id_o,
  output logic [XLEN-1:0]  data_o,
  output exception_t       ex_o
);

  logic             occupied_q, occupied_d;
  logic [TID_W-1:0] trans_id_q, trans_id_d;
  logic [XLEN-1:0]  data_q, data_d;
  exception_t       ex_q, ex_d;

  // Load wins over clear so a granted slot can be refilled in the same cycle.
  always_comb begin
    occupied_d = occupied_q;
    trans_id_d = trans_id_q;
    data_d     = data_q;
    ex_d       = ex_q;
    if (flush_i) begin
      occupied_d = 1'b0;
    end else if (load_i) begin
      occupied_d = 1'b1;
      trans_id_d = trans_id_i;
      data_d     = data_i;
      ex_d       = ex_i;
    end else if (clear_i) begin
      occupied_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occupied_q <= 1'b0;
      trans_id_q <= '0;
      data_q     <= '0;
      ex_q       <= '0;
    end else begin
      occupied_q <= occupied_d;
      trans_id_q <= trans_id_d;
      data_q     <= data_d;
      ex_q       <= ex_d;
    end
  end

  assign occupied_o = occupied_q;
  assign trans_id_o = trans_id_q;
  assign data_o     = data_q;
  assign ex_o       = ex_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter funnelling NR_REQ functional-unit results into one scoreboard
// writeback port, buffering one result per unit.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg = cva6_cfg_empty,
  parameter int unsigned NR_REQ  = 3,
  localparam int unsigned XLEN   = CVA6Cfg.XLEN,
  localparam int unsigned SRC_W  = idx_bits(NR_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [NR_REQ-1:0]        req_valid_i,
  output logic [NR_REQ-1:0]        req_ready_o,
  input  logic [TRANS_ID_BITS-1:0] req_trans_id_i [NR_REQ],
  input  logic [XLEN-1:0]          req_data_i     [NR_REQ],
  input  exception_t               req_ex_i       [NR_REQ],
  output logic                     wb_valid_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [XLEN-1:0]          wb_data_o,
  output exception_t               wb_ex_o,
  output logic [SRC_W-1:0]         wb_src_o
);

  logic [NR_REQ-1:0]        occupied;
  logic [NR_REQ-1:0]        grant;
  logic [NR_REQ-1:0]        load;
  logic [NR_REQ-1:0]        clear_slot;
  logic [TRANS_ID_BITS-1:0] slot_tid  [NR_REQ];
  logic [XLEN-1:0]          slot_data [NR_REQ];
  exception_t               slot_ex   [NR_REQ];

  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0] grant_idx;
  logic             any_occ;
  logic             found;
  int unsigned      idx;

  // First occupied slot at or after rr_ptr, wrapping at NR_REQ.
  always_comb begin
    grant_idx = '0;
    grant     = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned o = 0; o < NR_REQ; o++) begin
      idx = 32'(rr_ptr_q) + o;
      if (idx >= NR_REQ) idx = idx - NR_REQ;
      if (!found && occupied[idx]) begin
        found     = 1'b1;
        grant_idx = SRC_W'(idx);
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

  assign any_occ     = |occupied;
  assign req_ready_o = ~occupied | grant;
  assign load        = req_valid_i & req_ready_o & {NR_REQ{~flush_i}};
  assign clear_slot  = grant & {NR_REQ{~flush_i}};

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_occ && !flush_i) begin
      rr_ptr_d = (32'(grant_idx) == NR_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end

  for (genvar i = 0; i < NR_REQ; i++) begin : g_slot
    wb_arb_slot #(
      .XLEN (XLEN),
      .TID_W(TRANS_ID_BITS)
    ) u_slot (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .load_i    (load[i]),
      .clear_i   (clear_slot[i]),
      .flush_i   (flush_i),
      .trans_id_i(req_trans_id_i[i]),
      .data_i    (req_data_i[i]),
      .ex_i      (req_ex_i[i]),
      .occupied_o(occupied[i]),
      .trans_id_o(slot_tid[i]),
      .data_o    (slot_data[i]),
      .ex_o      (slot_ex[i])
    );
  end

  // Payload outputs are zeroed when idle so the scoreboard never sees stale ids.
  assign wb_valid_o    = any_occ & ~flush_i;
  assign wb_trans_id_o = any_occ ? slot_tid[grant_idx]  : '0;
  assign wb_data_o     = any_occ ? slot_data[grant_idx] : '0;
  assign wb_ex_o       = any_occ ? slot_ex[grant_idx]   : '0;
  assign wb_src_o      = any_occ ? grant_idx            : '0;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus a short random burst, checked every
// cycle against a slot/queue model of the round-robin writeback rules.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int N = 3;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     flush;
  logic [N-1:0]             req_valid;
  logic [N-1:0]             req_ready;
  logic [TRANS_ID_BITS-1:0] req_tid  [N];
  logic [63:0]              req_data [N];
  exception_t               req_ex   [N];
  logic                     wb_valid;
  logic [TRANS_ID_BITS-1:0] wb_tid;
  logic [63:0]              wb_data;
  exception_t               wb_ex;
  logic [1:0]               wb_src;

  int n_cmp  = 0;
  int n_fail = 0;

  wb_port_arbiter #(.NR_REQ(N)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (flush),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_trans_id_i(req_tid),
    .req_data_i    (req_data),
    .req_ex_i      (req_ex),
    .wb_valid_o    (wb_valid),
    .wb_trans_id_o (wb_tid),
    .wb_data_o     (wb_data),
    .wb_ex_o       (wb_ex),
    .wb_src_o      (wb_src)
  );

  // clock block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: per-FU buffered result plus the round-robin pointer
  bit                       m_occ  [N];
  logic [TRANS_ID_BITS-1:0] m_tid  [N];
  logic [63:0]              m_data [N];
  exception_t               m_ex   [N];
  int                       m_ptr;
  bit                       m_any;
  int                       m_g;
  logic [N-1:0]             m_ready;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_valid", 128'(wb_valid), 128'(0));
      check("rst_ready", 128'(req_ready), 128'(3'b111));
      check("rst_src", 128'(wb_src), 128'(0));
      for (int i = 0; i < N; i++) m_occ[i] = 0;
      m_ptr = 0;
    end else begin
      m_any = 0;
      m_g   = 0;
      for (int o = 0; o < N; o++) begin
        if (!m_any && m_occ[(m_ptr + o) % N]) begin
          m_any = 1;
          m_g   = (m_ptr + o) % N;
        end
      end
      for (int i = 0; i < N; i++) m_ready[i] = !m_occ[i] || (m_any && m_g == i);
      check("valid", 128'(wb_valid), 128'(m_any && !flush));
      check("ready", 128'(req_ready), 128'(m_ready));
      if (m_any) begin
        check("src", 128'(wb_src), 128'(m_g));
        check("tid", 128'(wb_tid), 128'(m_tid[m_g]));
        check("data", 128'(wb_data), 128'(m_data[m_g]));
        check("ex", 128'(wb_ex), 128'(m_ex[m_g]));
      end else begin
        check("idle_src", 128'(wb_src), 128'(0));
        check("idle_tid", 128'(wb_tid), 128'(0));
        check("idle_data", 128'(wb_data), 128'(0));
        check("idle_exv", 128'(wb_ex.valid), 128'(0));
      end
      if (flush) begin
        for (int i = 0; i < N; i++) m_occ[i] = 0;
      end else begin
        if (m_any) begin
          m_occ[m_g] = 0;
          m_ptr = (m_g + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && m_ready[i]) begin
            m_occ[i]  = 1;
            m_tid[i]  = req_tid[i];
            m_data[i] = req_data[i];
            m_ex[i]   = req_ex[i];
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [TRANS_ID_BITS-1:0] t, input logic [63:0] d);
    req_valid[i] = 1'b1;
    req_tid[i]   = t;
    req_data[i]  = d;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      req_tid[i]  = '0;
      req_data[i] = '0;
      req_ex[i]   = '0;
    end
    repeat (2) tick();
    check("lit_rst_valid", 128'(wb_valid), 128'(0));
    check("lit_rst_ready", 128'(req_ready), 128'(3'b111));
    rst_n = 1'b1;
    tick();

    // single request on FU1
    set_req(1, 3'd3, 64'hAB);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("single_valid", 128'(wb_valid), 128'(1));
    check("single_tid", 128'(wb_tid), 128'(3));
    check("single_data", 128'(wb_data), 128'(64'hAB));
    check("single_src", 128'(wb_src), 128'(1));
    tick();
    @(negedge clk);
    check("single_after", 128'(wb_valid), 128'(0));

    // FU2 alone brings the pointer back to 0
    set_req(2, 3'd5, 64'h55);
    tick();
    req_valid = '0;
    tick();

    // contention from pointer 0
    set_req(0, 3'd1, 64'h100);
    set_req(1, 3'd2, 64'h200);
    set_req(2, 3'd4, 64'h400);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("cont_src0", 128'(wb_src), 128'(0));
    check("cont_ready0", 128'(req_ready), 128'(3'b001));
    tick();
    @(negedge clk);
    check("cont_src1", 128'(wb_src), 128'(1));
    check("cont_ready1", 128'(req_ready), 128'(3'b011));
    tick();
    @(negedge clk);
    check("cont_src2", 128'(wb_src), 128'(2));
    check("cont_rdy2", 128'(req_ready[2]), 128'(1));
    tick();

    // wrap: pointer to 2 via FU1, then FU0 and FU2 together
    set_req(1, 3'd6, 64'h600);
    tick();
    req_valid = '0;
    tick();
    set_req(0, 3'd2, 64'h20);
    set_req(2, 3'd3, 64'h30);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("wrap_first", 128'(wb_src), 128'(2));
    tick();
    @(negedge clk);
    check("wrap_second", 128'(wb_src), 128'(0));
    tick();
    set_req(0, 3'd4, 64'h40);
    set_req(1, 3'd5, 64'h50);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("ptr_is_1", 128'(wb_src), 128'(1));
    tick();
    tick();

    // back-to-back on FU0
    for (int k = 0; k < 6; k++) begin
      set_req(0, 3'(k), 64'(k * 17));
      tick();
      @(negedge clk);
      check("b2b_valid", 128'(wb_valid), 128'(1));
      check("b2b_ready", 128'(req_ready[0]), 128'(1));
      check("b2b_tid", 128'(wb_tid), 128'(k));
    end
    req_valid = '0;
    tick();
    @(negedge clk);
    check("b2b_end", 128'(wb_valid), 128'(0));

    // flush with all slots full and a same-cycle request
    set_req(0, 3'd5, 64'h5);
    set_req(1, 3'd6, 64'h6);
    set_req(2, 3'd7, 64'h7);
    tick();
    req_valid = '0;
    set_req(1, 3'd1, 64'h11);
    flush = 1'b1;
    @(negedge clk);
    check("flush_valid", 128'(wb_valid), 128'(0));
    tick();
    flush = 1'b0;
    req_valid = '0;
    @(negedge clk);
    check("post_flush_valid", 128'(wb_valid), 128'(0));
    check("post_flush_ready", 128'(req_ready), 128'(3'b111));
    tick();

    // async reset between edges with two slots occupied
    set_req(0, 3'd2, 64'hC0);
    set_req(1, 3'd3, 64'hC1);
    tick();
    req_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 128'(wb_valid), 128'(0));
    check("arst_ready", 128'(req_ready), 128'(3'b111));
    check("arst_src", 128'(wb_src), 128'(0));
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("arst_after", 128'(wb_valid), 128'(0));
    tick();

    // random burst checked by the model
    for (int c = 0; c < 40; c++) begin
      req_valid = 3'($urandom_range(0, 7));
      flush = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < N; i++) begin
        req_tid[i]      = 3'($urandom_range(0, 7));
        req_data[i]     = {$urandom, $urandom};
        req_ex[i].cause = $urandom;
        req_ex[i].tval  = $urandom;
        req_ex[i].valid = 1'($urandom_range(0, 1));
      end
      tick();
    end
    req_valid = '0;
    flush = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
